// File: rtl/miyajiro_boot_pkg.sv
// Shared definitions for the MIYAJIRO boot loader and its host-side model.
package miyajiro_boot_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF  = 8'h99;
  localparam logic [7:0] READY_BYTE_DEF = 8'hAA;

  typedef enum logic [2:0] {
    SEND_SYNC,
    RECV_SIZE,
    RECV_PROG,
    SEND_READY,
    DONE,
    ERROR
  } boot_state_t;

endpackage

// File: rtl/uart_tx_sender.sv
// Issues one byte to UART_TX per request, respecting tx_busy and its one-cycle lag.
// Handshake: send_req is held with send_data until accepted=1; accepted is combinational
// and true in the cycle the byte is taken, tx_start pulses in the following cycle.
module uart_tx_sender (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       send_req,
  input  logic [7:0] send_data,
  input  logic       tx_busy,
  output logic       accepted,
  output logic       tx_start,
  output logic [7:0] tx_sdata
);

  logic       tx_start_q, tx_start_d;
  logic       guard_q, guard_d;
  logic [7:0] tx_sdata_q, tx_sdata_d;

  // tx_busy only rises the cycle after tx_start, so block that cycle and the next.
  always_comb begin
    accepted   = send_req && !tx_busy && !tx_start_q && !guard_q;
    tx_start_d = accepted;
    guard_d    = tx_start_q;
    tx_sdata_d = accepted ? send_data : tx_sdata_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_start_q <= 1'b0;
      guard_q    <= 1'b0;
      tx_sdata_q <= 8'h00;
    end else begin
      tx_start_q <= tx_start_d;
      guard_q    <= guard_d;
      tx_sdata_q <= tx_sdata_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_sdata = tx_sdata_q;

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: sync handshake, 4-byte little-endian size, program bytes packed into
// 32-bit imem words, then ready byte and boot_done.
module uart_program_loader
  import miyajiro_boot_pkg::*;
#(
  parameter int         IMEM_ADDR_WIDTH = 14,
  parameter logic [7:0] SYNC_BYTE       = SYNC_BYTE_DEF,
  parameter logic [7:0] READY_BYTE      = READY_BYTE_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [7:0]                 rx_rdata,
  input  logic                       rx_rdata_ready,
  input  logic                       rx_ferr,
  output logic [7:0]                 tx_sdata,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic                       imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]                imem_wdata,
  output logic [31:0]                program_size,
  output logic                       boot_done,
  output logic                       boot_err,
  output logic [2:0]                 dbg_state
);

  localparam logic [32:0] CAP_BYTES = 33'(4) << IMEM_ADDR_WIDTH;

  boot_state_t                state_q, state_d;
  logic [31:0]                cnt_q, cnt_d;
  logic [31:0]                size_q, size_d;
  logic [31:0]                word_q, word_d;
  logic                       imem_we_q, imem_we_d;
  logic [IMEM_ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]                imem_wdata_q, imem_wdata_d;
  logic                       boot_done_q, boot_done_d;
  logic                       boot_err_q, boot_err_d;

  logic        send_req, accepted;
  logic [7:0]  send_byte;
  logic [31:0] new_size, cnt_inc, merged;

  uart_tx_sender u_tx_sender (
    .clk       (clk),
    .reset_n   (reset_n),
    .send_req  (send_req),
    .send_data (send_byte),
    .tx_busy   (tx_busy),
    .accepted  (accepted),
    .tx_start  (tx_start),
    .tx_sdata  (tx_sdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    size_d       = size_q;
    word_d       = word_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    boot_done_d  = boot_done_q;
    send_req     = 1'b0;
    send_byte    = SYNC_BYTE;
    new_size     = {rx_rdata, size_q[31:8]};
    cnt_inc      = cnt_q + 32'd1;
    merged       = word_q;
    case (cnt_q[1:0])
      2'd0:    merged[7:0]   = rx_rdata;
      2'd1:    merged[15:8]  = rx_rdata;
      2'd2:    merged[23:16] = rx_rdata;
      default: merged[31:24] = rx_rdata;
    endcase

    case (state_q)
      SEND_SYNC: begin
        send_req  = 1'b1;
        send_byte = SYNC_BYTE;
        if (accepted) state_d = RECV_SIZE;
      end
      RECV_SIZE: begin
        if (rx_rdata_ready) begin
          if (rx_ferr) begin
            state_d = ERROR;
          end else begin
            size_d = new_size;
            cnt_d  = cnt_inc;
            if (cnt_q == 32'd3) begin
              cnt_d = 32'd0;
              if ({1'b0, new_size} > CAP_BYTES) state_d = ERROR;
              else if (new_size == 32'd0)       state_d = SEND_READY;
              else                              state_d = RECV_PROG;
            end
          end
        end
      end
      RECV_PROG: begin
        if (rx_rdata_ready) begin
          if (rx_ferr) begin
            state_d = ERROR;
          end else begin
            cnt_d  = cnt_inc;
            word_d = merged;
            // A short final word goes out with its unused upper bytes still zero.
            if (cnt_q[1:0] == 2'd3 || cnt_inc == size_q) begin
              imem_we_d    = 1'b1;
              imem_addr_d  = cnt_q[IMEM_ADDR_WIDTH+1:2];
              imem_wdata_d = merged;
              word_d       = 32'd0;
            end
            if (cnt_inc == size_q) state_d = SEND_READY;
          end
        end
      end
      SEND_READY: begin
        send_req  = 1'b1;
        send_byte = READY_BYTE;
        if (accepted) state_d = DONE;
      end
      DONE:    boot_done_d = 1'b1;
      ERROR:   ;
      default: state_d = ERROR;
    endcase

    boot_err_d = boot_err_q || (state_d == ERROR);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= SEND_SYNC;
      cnt_q        <= 32'd0;
      size_q       <= 32'd0;
      word_q       <= 32'd0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      boot_done_q  <= 1'b0;
      boot_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      size_q       <= size_d;
      word_q       <= word_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      boot_done_q  <= boot_done_d;
      boot_err_q   <= boot_err_d;
    end
  end

  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign program_size = size_q;
  assign boot_done    = boot_done_q;
  assign boot_err     = boot_err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Host-model bench for uart_program_loader: drives RX strobes, models UART_TX busy,
// and checks imem writes and TX bytes against expectations derived from the byte stream.
module tb_uart_program_loader;
  import miyajiro_boot_pkg::*;

  localparam int AW = 14;
  localparam int unsigned CAP = 4 * (2 ** AW);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    rx_rdata = 8'h00;
  logic          rx_rdata_ready = 1'b0;
  logic          rx_ferr = 1'b0;
  logic [7:0]    tx_sdata;
  logic          tx_start;
  logic          tx_busy;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [31:0]   program_size;
  logic          boot_done;
  logic          boot_err;
  logic [2:0]    dbg_state;

  uart_program_loader #(.IMEM_ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rx_rdata       (rx_rdata),
    .rx_rdata_ready (rx_rdata_ready),
    .rx_ferr        (rx_ferr),
    .tx_sdata       (tx_sdata),
    .tx_start       (tx_start),
    .tx_busy        (tx_busy),
    .imem_we        (imem_we),
    .imem_addr      (imem_addr),
    .imem_wdata     (imem_wdata),
    .program_size   (program_size),
    .boot_done      (boot_done),
    .boot_err       (boot_err),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- UART_TX model: busy for 10 cycles after tx_start ----------------
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  logic strobe_at_edge = 1'b0;
  always @(posedge clk) strobe_at_edge <= rx_rdata_ready;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0]       exp_tx_q[$];
  logic [AW+31:0]   exp_wr_q[$];
  logic [31:0]      mem_seen[int];
  int               tx_count = 0;
  int               wr_count = 0;
  logic [7:0]       last_tx = 8'h00;
  bit               ready_pending = 0;
  logic [7:0]       prog_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (ready_pending) begin
        chk("done_after_ready", boot_done, 1);
        ready_pending = 0;
      end
      if (imem_we) begin
        logic [AW+31:0] e;
        chk("we_latency", strobe_at_edge, 1);
        if (exp_wr_q.size() == 0) begin
          chk("unexpected_write", imem_addr, {AW{1'b1}} ^ imem_addr);
        end else begin
          e = exp_wr_q.pop_front();
          chk("wr_addr", imem_addr, e[AW+31:32]);
          chk("wr_data", imem_wdata, e[31:0]);
        end
        mem_seen[int'(imem_addr)] = imem_wdata;
        wr_count++;
      end
      if (tx_start) begin
        chk("tx_guard", tx_busy, 0);
        if (exp_tx_q.size() == 0) chk("unexpected_tx", tx_count, -1);
        else chk("tx_byte", tx_sdata, exp_tx_q.pop_front());
        if (tx_sdata == READY_BYTE_DEF) begin
          chk("done_at_ready", boot_done, 0);
          ready_pending = 1;
        end
        last_tx = tx_sdata;
        tx_count++;
      end else begin
        chk("tx_hold", tx_sdata, last_tx);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_rx(input logic [7:0] b, input logic f);
    @(negedge clk);
    rx_rdata = b;
    rx_rdata_ready = 1'b1;
    rx_ferr = f;
    @(negedge clk);
    rx_rdata_ready = 1'b0;
    rx_ferr = 1'b0;
    rx_rdata = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500; i++) begin
      if (exp_tx_q.size() == 0 && exp_wr_q.size() == 0) break;
      @(negedge clk);
    end
    chk("idle_timeout", exp_tx_q.size() + exp_wr_q.size(), 0);
    repeat (15) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rx_rdata_ready = 1'b0;
    rx_ferr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_sdata", tx_sdata, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_program_size", program_size, 0);
    chk("rst_boot_done", boot_done, 0);
    chk("rst_boot_err", boot_err, 0);
    exp_tx_q.delete();
    exp_wr_q.delete();
    mem_seen.delete();
    tx_count = 0;
    wr_count = 0;
    last_tx = 8'h00;
    ready_pending = 0;
    exp_tx_q.push_back(SYNC_BYTE_DEF);
    reset_n = 1'b1;
    wait_idle();
  endtask

  // Model: words are little-endian groups of four stream bytes; a word is expected only
  // if every byte it holds precedes the framing error.
  task automatic run_load(input logic [31:0] size, input int ferr_idx);
    bit over = (size > CAP);
    bit exp_err = over || (ferr_idx >= 0);
    int exp_words = 0;
    if (!over) begin
      for (int w = 0; w * 4 < int'(size); w++) begin
        int last_b = (w * 4 + 3 < int'(size)) ? w * 4 + 3 : int'(size) - 1;
        logic [31:0] data = 32'd0;
        if (ferr_idx < 0 || last_b < ferr_idx) begin
          for (int b = w * 4; b <= last_b; b++) data = data | (32'(prog_q[b]) << (8 * (b - w * 4)));
          exp_wr_q.push_back({AW'(w), data});
          exp_words++;
        end
      end
      if (ferr_idx < 0) exp_tx_q.push_back(READY_BYTE_DEF);
    end
    for (int i = 0; i < 4; i++) send_rx(size[8*i +: 8], 1'b0);
    if (!over) begin
      for (int k = 0; k < int'(size); k++) begin
        send_rx(prog_q[k], k == ferr_idx);
        if (k == ferr_idx) break;
      end
    end
    wait_idle();
    chk("boot_err", boot_err, exp_err);
    chk("boot_done", boot_done, !exp_err);
    if (!exp_err) chk("program_size", program_size, size);
    chk("wr_count", wr_count, exp_words);
    chk("tx_count", tx_count, exp_err ? 1 : 2);
  endtask

  task automatic set_prog(input int n, input logic [7:0] first, input logic [7:0] step);
    prog_q.delete();
    for (int i = 0; i < n; i++) prog_q.push_back(first + 8'(i) * step);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    // 1: single sync byte after reset, nothing more while idle
    do_reset();
    repeat (100) @(negedge clk);
    chk("t1_single_sync", tx_count, 1);

    // 2: eight bytes -> two full words
    do_reset();
    set_prog(8, 8'h11, 8'h11);
    run_load(32'd8, -1);
    chk("t2_word0", mem_seen[0], 32'h44332211);
    chk("t2_word1", mem_seen[1], 32'h88776655);
    send_rx(8'h5A, 1'b0);
    repeat (5) @(negedge clk);
    chk("t2_done_ignores_rx", wr_count, 2);

    // 3: six bytes -> partial last word, zero-filled
    do_reset();
    set_prog(6, 8'h01, 8'h01);
    run_load(32'd6, -1);
    chk("t3_word0", mem_seen[0], 32'h04030201);
    chk("t3_word1", mem_seen[1], 32'h00000605);

    // 4: empty program
    do_reset();
    prog_q.delete();
    run_load(32'd0, -1);

    // 5: oversize, then framing errors
    do_reset();
    run_load(CAP + 1, -1);
    do_reset();
    set_prog(8, 8'h11, 8'h11);
    run_load(32'd8, 3);
    do_reset();
    set_prog(12, 8'h11, 8'h11);
    run_load(32'd12, 6);
    chk("t5_word0_kept", mem_seen[0], 32'h44332211);

    // 6: reset in the middle of program reception, then full reload
    do_reset();
    exp_wr_q.push_back({AW'(0), 32'h44332211});
    for (int i = 0; i < 4; i++) send_rx((i == 0) ? 8'd8 : 8'd0, 1'b0);
    set_prog(8, 8'h11, 8'h11);
    for (int k = 0; k < 5; k++) send_rx(prog_q[k], 1'b0);
    chk("t6_mid_state", dbg_state, 3'(RECV_PROG));
    do_reset();
    run_load(32'd8, -1);
    chk("t6_reload_word1", mem_seen[1], 32'h88776655);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
